bstream_decoder: RTL
====================

# bstream_decoder

Stochastic bitstream decoder: counts the ones in a fixed window of 2^WIDTH valid samples of a serial unipolar bitstream and returns the result as a WIDTH-bit binary value. It is the reading end of the bitstream path. `baverage` and the other stream operators emit stochastic bits, and this block converts such a stream back to binary. In `tt_um_cejmu` it occupies mux slot `uio_in[1:0] = 2'b01`, driving `uo_out` with the decoded `bav0` output.

## Interface
Parameters:
- `WIDTH`, default 8: result width; window length N = 2^WIDTH valid samples.

Ports:
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level-sampled request to begin a window.
- `continuous`  in  1  when high, a finished window automatically starts the next one.
- `bit_in`  in  1  stream bit, counted when `bit_valid` is high.
- `bit_valid`  in  1  sample strobe.
- `value`  out  WIDTH  last completed result. Holds between windows.
- `sat`  out  1  last result saturated (ones count was N).
- `busy`  out  1  window in progress.
- `done`  out  1  one-cycle pulse when `value` and `sat` are updated.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start = 1` clears `ones_cnt` and `smp_cnt` and moves to RUN.
  - Otherwise stays in IDLE.
- RUN:
  - On each edge with `bit_valid = 1`: `smp_cnt += 1` and `ones_cnt += bit_in`.
  - When `smp_cnt` is all-ones and `bit_valid = 1` (the last sample), the sample is included and the state moves to DONE.
  - `start` is ignored in RUN.
- DONE, lasting exactly one cycle:
  - `done = 1`.
  - `value` and `sat` are already showing the new result.
  - Next state is RUN (counters cleared) if `continuous` or `start` is high, else IDLE.
- Width rules:
  - `smp_cnt` is WIDTH bits.
  - `ones_cnt` is WIDTH+1 bits, range 0..N.
  - Result: if `ones_cnt == N` then `value` = all-ones and `sat = 1`; else `value = ones_cnt[WIDTH-1:0]` and `sat = 0`.
  - The result is registered at the transition into DONE.
- `bit_in` is don't-care when `bit_valid = 0`. No sampling occurs in IDLE or DONE.
- `busy = 1` only in RUN.

## Timing
- Reset values: state IDLE, `value = 0`, `sat = 0`, `busy = 0`, `done = 0`, counters 0. The async assert takes effect immediately.
- Reset mid-window aborts it. The result is discarded, not flushed.
- Window timing with `start` high in cycle 0 and `bit_valid` held high:
  - `busy` is high in cycles 1..N; samples are taken in cycles 1..N.
  - `done`, `value` and `sat` update in cycle N+1, and `busy` is low in cycle N+1.
- Continuous mode:
  - The next window samples in cycles N+2..2N+1 and its `done` arrives in cycle 2N+2.
  - The result period is N+1 cycles; the one-sample gap is by design.
- With `bit_valid` gaps, latency is N valid samples + 1 cycle. `busy` stays high through the gaps.
- `value` never changes except in the DONE transition or on reset. There are no glitch outputs; all outputs are registers.

## Structure
- Shared package `cejmu_pkg`:
  - `bsd_state_t` enum (IDLE, RUN, DONE).
  - Default `BSD_WIDTH = 8`.
  - Mux-select constant `SEL_BSD = 2'b01`.
- Single module with no sub-module. The FSM, two counters and the result register are ~150 lines.
- Top level: instantiate as `bsd0`. Connections:
  - `bit_in = bav0_out`, `bit_valid = 1'b1`.
  - `start = ui_in[7]`, `continuous = ui_in[6]`.
  - Slot `2'b01` drives `value` to `uo_out`.

## Test plan
- Reset: assert `rst` asynchronously between edges with `start = 1` → all outputs 0 immediately; after release with `start = 0`, the block stays IDLE with outputs 0.
- Full stream: `WIDTH = 4`, `start` in cycle 0, `bit_in = 1`, `bit_valid = 1` → `busy` in cycles 1..16; `done` in cycle 17 with `value = 4'hF`, `sat = 1`.
- Half stream: `WIDTH = 8`, alternating 1,0 → `done` in cycle 257, `value = 128`, `sat = 0`; `value` holds 128 afterwards while IDLE.
- Gated samples: `WIDTH = 4`, `bit_valid` high on odd cycles only, `bit_in = 1` on valid cycles and 0 otherwise, `start` pulsed in RUN → `done` after the 16th valid sample, `value = 4'hF`, `sat = 1`; the ignored `start` causes no restart.
- Continuous: `WIDTH = 4`, `continuous = 1`, `bit_in = 0` for the first window and 1 for the second → first `done` in cycle 17 (`value = 0`), second `done` in cycle 34 (`value = 4'hF`, `sat = 1`).
- Abort: `WIDTH = 4` after a completed window with `value = 5`; restart, then assert `rst` at sample 6 → `value = 0`, `busy = 0`, `done` never pulses for the aborted window.

Source files
------------

// File: rtl/cejmu_pkg.sv
// Shared definitions for the cejmu bitstream blocks: decoder state type,
// default decoder width and the output-mux slot of the decoder.
package cejmu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsd_state_t;

    localparam int          BSD_WIDTH = 8;
    localparam logic [1:0]  SEL_BSD   = 2'b01;

endpackage

// File: rtl/bstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2^WIDTH valid
// samples and publishes the count as a WIDTH-bit value, saturating at N.
module bstream_decoder
    import cejmu_pkg::*;
#(
    parameter int WIDTH = BSD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] value,
    output logic             sat,
    output logic             busy,
    output logic             done
);

    // Ones count that means every sample in the window was a one.
    localparam logic [WIDTH:0] N_FULL = {1'b1, {WIDTH{1'b0}}};

    bsd_state_t       state, state_nxt;
    logic [WIDTH-1:0] smp_cnt;
    logic [WIDTH:0]   ones_cnt;
    logic [WIDTH:0]   ones_final;
    logic             clr;
    logic             smp_en;
    logic             last_smp;

    // Map a ones count 0..N to {sat, value}; a full count cannot be
    // represented in WIDTH bits, so it becomes all-ones with sat set.
    function automatic logic [WIDTH:0] saturate(input logic [WIDTH:0] ones);
        if (ones == N_FULL)
            return {1'b1, {WIDTH{1'b1}}};
        return {1'b0, ones[WIDTH-1:0]};
    endfunction

    // Count including the sample on the current edge, used for the last one.
    assign ones_final = ones_cnt + {{WIDTH{1'b0}}, bit_in};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and counter control strobes.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        smp_en    = 1'b0;
        last_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bit_valid) begin
                    smp_en = 1'b1;
                    if (smp_cnt == '1) begin
                        last_smp  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (continuous || start) begin
                    clr       = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample and ones counters; cleared when a window begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt  <= '0;
            ones_cnt <= '0;
        end else if (clr) begin
            smp_cnt  <= '0;
            ones_cnt <= '0;
        end else if (smp_en) begin
            smp_cnt  <= smp_cnt + 1'b1;
            ones_cnt <= ones_final;
        end
    end

    // Result register, loaded only on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (last_smp) begin
            {sat, value} <= saturate(ones_final);
        end
    end

    // Registered status flags follow the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

endmodule
